dac_serial_tx: RTL and testbench
================================

# dac_serial_tx

Parametrised serial DAC transmitter that supersedes the fixed two-byte DAC write sequencer. On each sample tick it shifts up to `N_CH` words of `DATA_W` bits MSB-first to an external serial DAC, drives frame select, bit clock and load strobe, and selects per-channel or simultaneous output update. It sits between the sine-sample generator (parallel data, tick) and the DAC pins.

## Interface
- `DATA_W`, 16, bits per channel word (≥2)
- `N_CH`, 2, number of channels per frame (≥1)
- `CLK_DIV`, 2, clk cycles per `sclk` half-period (≥1)
- `LD_MODE`, 0, 0 = `ld` pulse after every channel, 1 = single `ld` after last enabled channel
- `clk`  in  1  clock
- `RST`  in  1  reset, synchronous, active-high
- `start`  in  1  sample tick; sampled only in IDLE
- `data`  in  N_CH*DATA_W  channel words, ch0 in LSB slice; captured at LOAD
- `ch_en`  in  N_CH  channel enable mask; captured at LOAD
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at frame end
- `cs`  out  1  active-high shift-register enable, high only during SHIFT
- `sclk`  out  1  serial bit clock
- `sdo`  out  1  serial data, MSB first
- `ch_sel`  out  max(1,clog2(N_CH))  index of channel being shifted/latched
- `ld`  out  1  one-cycle active-high DAC load strobe

## Operation
- Reset: state IDLE; `busy`,`done`,`cs`,`sclk`,`sdo`,`ld` = 0; `ch_sel` = 0; shadow data/mask cleared. `RST` mid-frame aborts immediately, no `ld`, no `done`.
- States: IDLE, LOAD, SHIFT, GAP, LATCH, DONE.
- IDLE: `start`=1 → LOAD. `start` in any other state ignored (not queued).
- LOAD (1 cycle): capture `data`,`ch_en`; `ch_sel` ← lowest enabled index. Mask all-zero → DONE directly (no `cs`, no `ld`).
- SHIFT: `cs`=1; each bit lasts 2·CLK_DIV cycles: `sclk`=0 first CLK_DIV cycles, 1 second CLK_DIV; `sdo` updates at bit start (sclk low). DATA_W bits → GAP.
- GAP (1 cycle): `cs`=0, `sclk`=0, `sdo`=0. LD_MODE=0 → LATCH; LD_MODE=1 → LATCH if no higher enabled channel, else SHIFT with `ch_sel` ← next enabled index.
- LATCH (1 cycle): `ld`=1. Next enabled channel exists → SHIFT (advance `ch_sel`); else DONE.
- DONE (1 cycle): `done`=1 → IDLE.
- Disabled channels are skipped with zero cycles; `ch_sel` never wraps within a frame.

## Timing
- `start` sampled at cycle 0 → LOAD cycle 1 → first SHIFT cycle 2; first `sdo` bit valid cycle 2.
- SHIFT length per channel = DATA_W·2·CLK_DIV cycles.
- Frame length, E enabled channels: LD_MODE=1: 2 + E·(SHIFT+1) + 1 + 1; LD_MODE=0: 2 + E·(SHIFT+2) + 1.
- `sclk` rising edge mid-bit; DAC samples `sdo` on rising edge; `sdo` stable CLK_DIV cycles either side.
- `busy` rises cycle 1, falls the cycle after DONE; `start` coincident with DONE is ignored.
- All outputs registered; no combinational path input→output.

## Structure
- Package `dac_tx_pkg`: state encoding constants, LD_MODE constants, channel-index width function.
- Sub-module `dac_bit_timer`: CLK_DIV prescaler + bit counter producing `sclk`, bit-start strobe and last-bit flag; restarted at SHIFT entry.
- Top holds FSM, shadow shift register, enabled-channel search (priority encoder above current `ch_sel`).

## Test plan
- Defaults, `ch_en`=2'b11, LD_MODE=1, `data`={16'h8001,16'hA5C3}, `start` cycle 0 → ch0 bits 1010_0101_1100_0011 cycles 2–65, GAP 66, ch1 8001 cycles 67–130, `ld` cycle 132, `done` cycle 133.
- Same, LD_MODE=0 → `ld` at cycles 67 and 133, `done` 134, `ch_sel`=1 from 68.
- `ch_en`=2'b10 → only ch1 shifted cycles 2–65, `ch_sel`=1 throughout; `ch_en`=0 → `done` cycle 2, `cs`/`ld` never high.
- `start` held high through frame → exactly one frame; new frame only from `start` sampled in IDLE.
- `RST` at cycle 40 → next cycle all outputs 0, IDLE; no `ld`/`done`; subsequent `start` yields clean full frame.
- CLK_DIV=1, DATA_W=8, N_CH=3 → `sclk` toggles every cycle, SHIFT 16 cycles, `ch_sel` 0,1,2.

Source files
------------

// File: rtl/dac_tx_pkg.sv
// dac_tx_pkg
//   Shared definitions for the serial DAC transmitter: FSM state encoding,
//   load-strobe mode constants and the channel-index width helper.
package dac_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_LATCH,
    ST_DONE
  } state_t;

  // ld after every channel, or a single ld after the last enabled channel
  localparam int LD_EACH = 0;
  localparam int LD_LAST = 1;

  // Width of a channel index; a single-channel build still gets one bit.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/dac_bit_timer.sv
// dac_bit_timer
//   Bit timing for the serial DAC link. A CLK_DIV prescaler toggles sclk every
//   CLK_DIV cycles while running; a bit lasts one full sclk period (low half
//   first). Restarted at each SHIFT entry so every word begins on a fresh bit.
// Ports:
//   clk, RST   clock, synchronous active-high reset
//   restart    next cycle is the first cycle of a new word
//   run        current cycle is a shift cycle
//   sclk       registered serial bit clock
//   bit_adv    the current cycle is the last of a bit (next cycle starts a new bit)
//   last_bit   the bit being shifted is the final bit of the word
module dac_bit_timer
  import dac_tx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic restart,
  input  logic run,
  output logic sclk,
  output logic bit_adv,
  output logic last_bit
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             half_end;

  assign half_end = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign bit_adv  = run && half_end && sclk_q;
  assign last_bit = (bit_q == BIT_W'(DATA_W - 1));
  assign sclk     = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    bit_d  = bit_q;
    if (restart) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
      bit_d  = '0;
    end else if (run) begin
      if (half_end) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
        // the bit ends as the high half ends
        if (sclk_q) bit_d = bit_q + BIT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      bit_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/dac_serial_tx.sv
// dac_serial_tx
//   Serial DAC transmitter. On a start tick it captures up to N_CH words and
//   shifts each enabled one MSB-first with cs/sclk/sdo, then strobes ld either
//   after every channel (LD_MODE=0) or once after the last one (LD_MODE=1).
//   Every output is a flop loaded from the next-state view of the FSM.
// Ports:
//   clk, RST   clock, synchronous active-high reset (aborts a frame)
//   start      sample tick, honoured only in IDLE
//   data       N_CH words, channel 0 in the LSB slice
//   ch_en      channel enable mask
//   busy       high outside IDLE
//   done       one-cycle pulse at frame end
//   cs         high while a word is being shifted
//   sclk, sdo  serial bit clock and data
//   ch_sel     channel currently shifted / latched
//   ld         one-cycle DAC load strobe
module dac_serial_tx
  import dac_tx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int N_CH    = 2,
  parameter int CLK_DIV = 2,
  parameter int LD_MODE = 0
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic                        start,
  input  logic [N_CH*DATA_W-1:0]      data,
  input  logic [N_CH-1:0]             ch_en,
  output logic                        busy,
  output logic                        done,
  output logic                        cs,
  output logic                        sclk,
  output logic                        sdo,
  output logic [ch_idx_w(N_CH)-1:0]   ch_sel,
  output logic                        ld
);

  localparam int CW = ch_idx_w(N_CH);

  state_t                   state_q, state_d;
  logic [N_CH*DATA_W-1:0]   data_q, data_d, src_data;
  logic [N_CH-1:0]          mask_q, mask_d, src_mask;
  logic [CW-1:0]            ch_sel_q, ch_sel_d;
  logic [DATA_W-1:0]        sreg_q, sreg_d, next_word;
  logic [CW:0]              search;
  int                       search_from;
  logic                     busy_q, busy_d, done_q, done_d, cs_q, cs_d;
  logic                     sdo_q, sdo_d, ld_q, ld_d;
  logic                     timer_restart, timer_run, bit_adv, last_bit;

  // Lowest enabled channel at or above 'from'; MSB of the result flags a hit.
  function automatic logic [CW:0] find_en(input logic [N_CH-1:0] mask, input int from);
    logic [CW:0] res;
    res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) res = {1'b1, CW'(i)};
    end
    return res;
  endfunction

  assign timer_run = (state_q == ST_SHIFT);

  dac_bit_timer #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .RST      (RST),
    .restart  (timer_restart),
    .run      (timer_run),
    .sclk     (sclk),
    .bit_adv  (bit_adv),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    ch_sel_d = ch_sel_q;
    sreg_d   = sreg_q;
    // In LOAD the search runs on the live inputs so the first word is ready
    // for the very first SHIFT cycle; later it looks above the current channel.
    src_data    = (state_q == ST_LOAD) ? data  : data_q;
    src_mask    = (state_q == ST_LOAD) ? ch_en : mask_q;
    search_from = (state_q == ST_LOAD) ? 0 : int'(ch_sel_q) + 1;
    search      = find_en(src_mask, search_from);
    next_word   = src_data[int'(search[CW-1:0]) * DATA_W +: DATA_W];

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        data_d = data;
        mask_d = ch_en;
        if (search[CW]) begin
          ch_sel_d = search[CW-1:0];
          sreg_d   = next_word;
          state_d  = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (bit_adv) begin
          if (last_bit) state_d = ST_GAP;
          else          sreg_d  = {sreg_q[DATA_W-2:0], 1'b0};
        end
      end
      ST_GAP: begin
        if (LD_MODE == LD_EACH || !search[CW]) begin
          state_d = ST_LATCH;
        end else begin
          ch_sel_d = search[CW-1:0];
          sreg_d   = next_word;
          state_d  = ST_SHIFT;
        end
      end
      ST_LATCH: begin
        if (search[CW]) begin
          ch_sel_d = search[CW-1:0];
          sreg_d   = next_word;
          state_d  = ST_SHIFT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    timer_restart = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    cs_d   = (state_d == ST_SHIFT);
    ld_d   = (state_d == ST_LATCH);
    sdo_d  = (state_d == ST_SHIFT) && sreg_d[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      ch_sel_q <= '0;
      sreg_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      sdo_q    <= 1'b0;
      ld_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      ch_sel_q <= ch_sel_d;
      sreg_q   <= sreg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      sdo_q    <= sdo_d;
      ld_q     <= ld_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign cs     = cs_q;
  assign sdo    = sdo_q;
  assign ld     = ld_q;
  assign ch_sel = ch_sel_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx
//   Drives three transmitter builds from a shared clock/reset/start:
//   A = defaults with LD_MODE=1, B = defaults with LD_MODE=0,
//   C = DATA_W=8, N_CH=3, CLK_DIV=1, LD_MODE=0.
//   Expected pin values per cycle come from a frame walk over the enabled
//   channels (shift windows, gaps, latches, done) computed from the frame rules.
module tb_dac_serial_tx;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs;
    logic       sclk;
    logic       sdo;
    logic       ld;
    logic [1:0] sel;
  } obs_t;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] data_ab;
  logic [1:0]  en_ab;
  logic [23:0] data_c;
  logic [2:0]  en_c;

  logic busy_a, done_a, cs_a, sclk_a, sdo_a, ld_a;
  logic busy_b, done_b, cs_b, sclk_b, sdo_b, ld_b;
  logic busy_c, done_c, cs_c, sclk_c, sdo_c, ld_c;
  logic       ch_sel_a, ch_sel_b;
  logic [1:0] ch_sel_c;

  int tests_run  = 0;
  int fail_count = 0;

  logic [2:0][15:0] w_ab, w_c;
  logic [2:0]       m_ab, m_c;

  always #5 clk = ~clk;

  dac_serial_tx #(.DATA_W(16), .N_CH(2), .CLK_DIV(2), .LD_MODE(1)) dut_a (
    .clk(clk), .RST(RST), .start(start), .data(data_ab), .ch_en(en_ab),
    .busy(busy_a), .done(done_a), .cs(cs_a), .sclk(sclk_a), .sdo(sdo_a),
    .ch_sel(ch_sel_a), .ld(ld_a));

  dac_serial_tx #(.DATA_W(16), .N_CH(2), .CLK_DIV(2), .LD_MODE(0)) dut_b (
    .clk(clk), .RST(RST), .start(start), .data(data_ab), .ch_en(en_ab),
    .busy(busy_b), .done(done_b), .cs(cs_b), .sclk(sclk_b), .sdo(sdo_b),
    .ch_sel(ch_sel_b), .ld(ld_b));

  dac_serial_tx #(.DATA_W(8), .N_CH(3), .CLK_DIV(1), .LD_MODE(0)) dut_c (
    .clk(clk), .RST(RST), .start(start), .data(data_c), .ch_en(en_c),
    .busy(busy_c), .done(done_c), .cs(cs_c), .sclk(sclk_c), .sdo(sdo_c),
    .ch_sel(ch_sel_c), .ld(ld_c));

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs at cycle t of a frame whose start was sampled at t=0.
  function automatic obs_t model(input int t, input int dw, input int cdiv, input int ldm,
                                 input logic [2:0][15:0] w, input logic [2:0] m,
                                 output logic sel_care);
    obs_t o;
    int   pos, s, last, b, ph;
    o = '0;
    sel_care = 1'b0;
    if (t < 1) return o;
    o.busy = 1'b1;
    if (t == 1) return o;
    s = dw * 2 * cdiv;
    pos = 2;
    last = -1;
    for (int i = 0; i < 3; i++) if (m[i]) last = i;
    for (int c = 0; c < 3; c++) begin
      if (m[c]) begin
        o.sel = 2'(c);
        if (t >= pos && t < pos + s) begin
          b  = (t - pos) / (2 * cdiv);
          ph = (t - pos) % (2 * cdiv);
          o.cs   = 1'b1;
          o.sclk = (ph >= cdiv);
          o.sdo  = w[c][dw - 1 - b];
          sel_care = 1'b1;
          return o;
        end
        pos += s;
        if (t == pos) begin
          sel_care = 1'b1;
          return o;
        end
        pos++;
        if (ldm == 0 || c == last) begin
          if (t == pos) begin
            o.ld = 1'b1;
            sel_care = 1'b1;
            return o;
          end
          pos++;
        end
      end
    end
    o.sel = '0;
    if (t == pos) begin
      o.done = 1'b1;
      return o;
    end
    return '0;
  endfunction

  // Cycle of the done pulse, from the closed-form frame length.
  function automatic int done_time(input int dw, input int cdiv, input int ldm, input logic [2:0] m);
    int e, s;
    e = $countones(m);
    s = dw * 2 * cdiv;
    if (e == 0) return 2;
    return (ldm == 1) ? 2 + e * (s + 1) + 1 : 2 + e * (s + 2);
  endfunction

  task automatic compare_dut(input string name, input int t, input obs_t got, input obs_t exp,
                             input logic care);
    obs_t g, e;
    g = got;
    e = exp;
    if (!care) begin
      g.sel = '0;
      e.sel = '0;
    end
    check_output($sformatf("%s t=%0d", name, t), {8'h00, g}, {8'h00, e});
  endtask

  task automatic compare_all(input int t, input logic after_rst);
    obs_t ea, eb, ec, ga, gb, gc;
    logic ca, cb, cc;
    ga = {busy_a, done_a, cs_a, sclk_a, sdo_a, ld_a, 1'b0, ch_sel_a};
    gb = {busy_b, done_b, cs_b, sclk_b, sdo_b, ld_b, 1'b0, ch_sel_b};
    gc = {busy_c, done_c, cs_c, sclk_c, sdo_c, ld_c, ch_sel_c};
    if (after_rst) begin
      ea = '0; eb = '0; ec = '0;
      ca = 1'b1; cb = 1'b1; cc = 1'b1;
    end else begin
      ea = model(t, 16, 2, 1, w_ab, m_ab, ca);
      eb = model(t, 16, 2, 0, w_ab, m_ab, cb);
      ec = model(t, 8, 1, 0, w_c, m_c, cc);
    end
    compare_dut("dutA", t, ga, ea, ca);
    compare_dut("dutB", t, gb, eb, cb);
    compare_dut("dutC", t, gc, ec, cc);
  endtask

  // One frame: start held for 'hold' cycles (negative = through the shortest
  // frame's done pulse), optional reset at cycle rst_at (negative = none).
  task automatic apply_stimulus(input logic [31:0] d_ab, input logic [1:0] e_ab,
                                input logic [23:0] d_c, input logic [2:0] e_c,
                                input int hold, input int rst_at);
    int da, db, dc, end_t, hold_len;
    w_ab = {16'h0000, d_ab[31:16], d_ab[15:0]};
    m_ab = {1'b0, e_ab};
    w_c  = {8'h00, d_c[23:16], 8'h00, d_c[15:8], 8'h00, d_c[7:0]};
    m_c  = e_c;
    da = done_time(16, 2, 1, m_ab);
    db = done_time(16, 2, 0, m_ab);
    dc = done_time(8, 1, 0, m_c);
    end_t = (da > db) ? da : db;
    end_t = ((dc > end_t) ? dc : end_t) + 2;
    hold_len = hold;
    if (hold < 0) begin
      hold_len = (da < db) ? da : db;
      hold_len = ((dc < hold_len) ? dc : hold_len) + 1;
    end
    if (rst_at >= 0) end_t = rst_at + 4;
    for (int t = 0; t <= end_t; t++) begin
      @(negedge clk);
      compare_all(t, (rst_at >= 0) && (t > rst_at));
      start = (t < hold_len);
      RST   = (t == rst_at);
      if (t <= 1) begin
        data_ab = d_ab; en_ab = e_ab; data_c = d_c; en_c = e_c;
      end else begin
        data_ab = $urandom;
        en_ab   = 2'($urandom_range(0, 3));
        data_c  = 24'($urandom);
        en_c    = 3'($urandom_range(0, 7));
      end
    end
    start = 1'b0;
    RST   = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    start = 1'b0;
    data_ab = '0; en_ab = '0; data_c = '0; en_c = '0;
    repeat (3) @(negedge clk);
    compare_all(0, 1'b1);
    RST = 1'b0;
    @(negedge clk);
    compare_all(0, 1'b1);

    apply_stimulus({16'h8001, 16'hA5C3}, 2'b11, 24'h3C_96_E1, 3'b111, 1, -1);
    apply_stimulus({16'h8001, 16'hA5C3}, 2'b10, 24'h5A_F0_0F, 3'b010, 1, -1);
    apply_stimulus({16'h8001, 16'hA5C3}, 2'b00, 24'h12_34_56, 3'b000, 2, -1);
    apply_stimulus({16'h1234, 16'hFEDC}, 2'b11, 24'hA1_B2_C3, 3'b101, -1, -1);
    apply_stimulus({16'hC0DE, 16'hBEEF}, 2'b11, 24'h77_88_99, 3'b111, 1, 40);
    apply_stimulus({16'h8001, 16'hA5C3}, 2'b11, 24'h3C_96_E1, 3'b111, 1, -1);

    for (int n = 0; n < 20; n++) begin
      apply_stimulus($urandom, 2'($urandom_range(0, 3)), 24'($urandom),
                     3'($urandom_range(0, 7)), $urandom_range(1, 3), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
